// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and GF(2^8) helpers for the iterative AES-128
// decryption core.
//   state_e          : controller states
//   AES_NR           : number of AES-128 rounds
//   RCON_FIRST/LAST  : first and last round constants of the key schedule
//   xtime/inv_xtime  : multiply / divide by x in GF(2^8) (rcon stepping)
//   gf_mul           : multiply by the InvMixColumns coefficients 9, b, d, e
//   inv_shift_rows   : AES InvShiftRows on a 128-bit block
//   inv_mix_columns  : AES InvMixColumns on a 128-bit block
// Block byte 0 is bits [127:120]; byte i sits at row i%4, column i/4.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ADDKEY = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4
  } state_e;

  localparam int         AES_NR     = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Exact inverse of xtime over the rcon sequence: 0x1b is the only value
  // reached through the reduction, and it came from 0x80.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return (x == 8'h1b) ? 8'h80 : {1'b0, x[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h9:    return x8 ^ x;
      4'hb:    return x8 ^ x2 ^ x;
      4'hd:    return x8 ^ x4 ^ x;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// -----------------------------------------------------------------------------
// aes_inv_sbox
// Inverse AES S-box, 8-bit combinational lookup.
//   a : input byte
//   y : InvSubBytes(a)
// -----------------------------------------------------------------------------
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:2047] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y = TBL[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, 8-bit combinational lookup.
//   a : input byte
//   y : SubBytes(a)
// -----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry n occupies bits [8n +: 8] counted from the left of the literal.
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES-128 decryption, one round per clock. The cipher key is first
// expanded forward to round key 10, then the schedule is rolled backwards one
// key per round while the block is decrypted.
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset, aborts any operation
//   start       : request pulse, sampled only in IDLE
//   key         : cipher key (round key 0), byte 0 = bits [127:120]
//   cipher_text : ciphertext block, same byte order
//   busy        : high while an operation is in flight
//   done        : one-cycle pulse, plain_text valid
//   plain_text  : decrypted block, held until the next done
// Latency: start accepted at edge E0, done high after edge E21.
// -----------------------------------------------------------------------------
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] cipher_text,
  output logic         busy,
  output logic         done,
  output logic [127:0] plain_text
);

  localparam logic [3:0] LAST_KEYEXP = 4'(AES_NR - 1);
  localparam logic [3:0] LAST_ROUND  = 4'(AES_NR - 2);

  state_e       state_q, state_d;
  logic [127:0] blk_q,   blk_d;
  logic [127:0] rk_q,    rk_d;
  logic [7:0]   rcon_q,  rcon_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic         done_q,  done_d;
  logic [127:0] pt_q,    pt_d;

  // ---------------------------------------------------------------------------
  // Key schedule: one forward or one backward step per cycle
  // ---------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sub_in, sub_out, g;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_next, rk_prev;

  assign {w0, w1, w2, w3} = rk_q;

  // Backward step recovers the previous w3 first; it feeds the S-boxes.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // The four forward S-boxes are shared between expansion and roll-back.
  assign sub_in = (state_q == KEYEXP) ? w3 : p3;

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*i +: 8]),
      .y (sub_out[8*i +: 8])
    );
  end

  // SubWord commutes with RotWord, so rotate after substitution.
  assign g = {sub_out[23:0], sub_out[31:24]} ^ {rcon_q, 24'h0};

  assign n0 = w0 ^ g;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};
  assign rk_prev = {w0 ^ g, p1, p2, p3};

  // ---------------------------------------------------------------------------
  // Block path: InvShiftRows -> InvSubBytes, shared by ROUND and FINAL
  // ---------------------------------------------------------------------------
  logic [127:0] isr, isb, round_out, final_out;

  assign isr = inv_shift_rows(blk_q);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .a (isr[8*i +: 8]),
      .y (isb[8*i +: 8])
    );
  end

  assign final_out = isb ^ rk_q;
  assign round_out = inv_mix_columns(final_out);

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pt_d    = pt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = cipher_text;
          rk_d    = key;
          rcon_d  = RCON_FIRST;
          cnt_d   = '0;
          state_d = KEYEXP;
        end
      end

      KEYEXP: begin
        rk_d  = rk_next;
        cnt_d = cnt_q + 4'd1;
        // rcon stays on the value that produced round key 10, so the first
        // backward step can reuse it.
        if (cnt_q == LAST_KEYEXP) begin
          state_d = ADDKEY;
        end else begin
          rcon_d = xtime(rcon_q);
        end
      end

      ADDKEY: begin
        blk_d   = blk_q ^ rk_q;
        rk_d    = rk_prev;
        rcon_d  = inv_xtime(rcon_q);
        cnt_d   = '0;
        state_d = ROUND;
      end

      ROUND: begin
        blk_d  = round_out;
        rk_d   = rk_prev;
        rcon_d = inv_xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND) begin
          state_d = FINAL;
        end
      end

      FINAL: begin
        pt_d    = final_out;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // datapath included, is reset so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pt_q    <= pt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign plain_text = pt_q;

  // Compile-time consistency of the schedule constants.
  if (RCON_LAST != 8'h36) begin : g_bad_rcon
    $error("RCON_LAST does not match AES-128");
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Directed bench for aes_decrypt_iter. A transaction-level model tracks what
// busy/done/plain_text must be every cycle (fixed 21-clock latency, start
// ignored while busy, synchronous reset abort, result from a known-answer
// table keyed by the latched key/ciphertext). Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] cipher_text;
  logic         busy;
  logic         done;
  logic [127:0] plain_text;

  aes_decrypt_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key         (key),
    .cipher_text (cipher_text),
    .busy        (busy),
    .done        (done),
    .plain_text  (plain_text)
  );

  always #5 clk = ~clk;

  // Known-answer vectors: FIPS-197 C.1, FIPS-197 App. B, all-zero key.
  localparam logic [127:0] V_KEY [3] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h00000000000000000000000000000000
  };
  localparam logic [127:0] V_CT [3] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e
  };
  localparam logic [127:0] V_PT [3] = '{
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00000000000000000000000000000000
  };
  localparam int LATENCY = 21;

  int n_cmp = 0;
  int n_bad = 0;
  bit compare_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] lookup(input logic [127:0] k, input logic [127:0] c);
    for (int i = 0; i < 3; i++) begin
      if (V_KEY[i] == k && V_CT[i] == c) return V_PT[i];
    end
    return 'x;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_pt   = '0;
  logic [127:0] m_exp  = '0;
  int           m_rem  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_pt   = '0;
      m_rem  = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_rem  = LATENCY;
          m_exp  = lookup(key, cipher_text);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_pt   = m_exp;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("done", 128'(done), 128'(m_done));
      check("plain_text", plain_text, m_pt);
      if (busy && done) check("busy_and_done", 128'(1), 128'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  int busy_cnt;

  task automatic do_start(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key         = k;
    cipher_text = c;
    start       = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic wait_done(output int cyc, output logic [127:0] pt_seen);
    cyc     = -1;
    pt_seen = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        cyc     = i;
        pt_seen = plain_text;
        break;
      end
    end
  endtask

  initial begin
    int           cyc;
    int           n_done;
    logic [127:0] pt_seen;
    logic [127:0] first_pt;

    // Reset held with start asserted: outputs stay cleared.
    rst_n       = 1'b0;
    start       = 1'b1;
    key         = V_KEY[0];
    cipher_text = V_CT[0];
    repeat (2) @(negedge clk);
    compare_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      check("reset_pt", plain_text, 128'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // FIPS-197 C.1: latency and busy length.
    do_start(V_KEY[0], V_CT[0]);
    wait_done(cyc, pt_seen);
    check("c1_latency", 128'(cyc), 128'(21));
    check("c1_busy_cycles", 128'(busy_cnt), 128'(21));
    check("c1_pt", pt_seen, 128'h00112233445566778899aabbccddeeff);

    // FIPS-197 App. B.
    do_start(V_KEY[1], V_CT[1]);
    wait_done(cyc, pt_seen);
    check("appb_latency", 128'(cyc), 128'(21));
    check("appb_pt", pt_seen, 128'h3243f6a8885a308d313198a2e0370734);

    // Zero key, then back-to-back start in the done cycle.
    do_start(V_KEY[2], V_CT[2]);
    wait_done(cyc, pt_seen);
    check("zero_pt", pt_seen, 128'h0);
    first_pt    = plain_text;
    key         = V_KEY[0];
    cipher_text = V_CT[0];
    start       = 1'b1;
    cyc         = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (!done) check("b2b_hold", plain_text, first_pt);
      if (done) begin
        cyc     = i;
        pt_seen = plain_text;
        break;
      end
    end
    check("b2b_gap", 128'(cyc), 128'(22));
    check("b2b_pt", pt_seen, 128'h00112233445566778899aabbccddeeff);

    // Starts while busy with changed inputs are ignored.
    do_start(V_KEY[1], V_CT[1]);
    n_done  = 0;
    pt_seen = 'x;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        pt_seen = plain_text;
      end
      if (i == 5 || i == 15) begin
        key         = {$urandom, $urandom, $urandom, $urandom};
        cipher_text = {$urandom, $urandom, $urandom, $urandom};
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ignore_done_count", 128'(n_done), 128'(1));
    check("ignore_pt", pt_seen, 128'h3243f6a8885a308d313198a2e0370734);

    // Reset mid-operation aborts.
    do_start(V_KEY[0], V_CT[0]);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_pt", plain_text, 128'h0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 128'(n_done), 128'(0));
    do_start(V_KEY[0], V_CT[0]);
    wait_done(cyc, pt_seen);
    check("after_abort_latency", 128'(cyc), 128'(21));
    check("after_abort_pt", pt_seen, 128'h00112233445566778899aabbccddeeff);

    repeat (3) @(negedge clk);
    compare_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
